data_buffer: RTL and testbench

DATA_BUFFER -- requirements
Module: data_buffer

---
 rtl/data_buffer.sv | 88 ++++++++
 tb/tb_data_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_buffer.sv
// 64 x 8-bit first-word-fall-through FIFO shared by host (AHB) and USB sides.
// Optional macro DATA_BUFFER_CLEAR_MEM_EN: clear also zeroes all storage entries.
module data_buffer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       flush,
  input  logic       clear,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       store_rx_packet_data,
  input  logic [7:0] rx_packet_data,
  input  logic       get_rx_data,
  input  logic       get_tx_packet_data,
  output logic [6:0] buffer_occupancy,
  output logic [7:0] rx_data,
  output logic [7:0] tx_packet_data
);

  logic [6:0] wptr_q, wptr_d;
  logic [6:0] rptr_q, rptr_d;
  logic [7:0] mem_q [64];
  logic [7:0] mem_d [64];

  logic [6:0] occ;
  logic       empty;
  logic       full;
  logic       do_store;
  logic       do_get;
  logic [7:0] wr_byte;
  logic [7:0] head;

  // 7-bit pointers: difference is 0..64, so bit 6 alone flags full.
  always_comb begin
    occ      = wptr_q - rptr_q;
    empty    = (occ == 7'd0);
    full     = occ[6];
    do_store = (store_tx_data | store_rx_packet_data) & ~full;
    do_get   = (get_rx_data | get_tx_packet_data) & ~empty;
    wr_byte  = store_rx_packet_data ? rx_packet_data : tx_data;
    head     = empty ? '0 : mem_q[rptr_q[5:0]];
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    mem_d  = mem_q;
    if (flush || clear) begin
      wptr_d = '0;
      rptr_d = '0;
`ifdef DATA_BUFFER_CLEAR_MEM_EN
      if (clear) begin
        for (int unsigned i = 0; i < 64; i++) begin
          mem_d[i[5:0]] = '0;
        end
      end
`endif
    end else begin
      if (do_store) begin
        mem_d[wptr_q[5:0]] = wr_byte;
        wptr_d             = wptr_q + 7'd1;
      end
      if (do_get) begin
        rptr_d = rptr_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int unsigned i = 0; i < 64; i++) begin
        mem_q[i[5:0]] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      for (int unsigned i = 0; i < 64; i++) begin
        mem_q[i[5:0]] <= mem_d[i[5:0]];
      end
    end
  end

  assign buffer_occupancy = occ;
  assign rx_data          = head;
  assign tx_packet_data   = head;

endmodule

// File: tb/tb_data_buffer.sv
// Directed, table-driven bench for data_buffer with hand-computed expectations.
module tb_data_buffer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       flush, clear;
  logic       store_tx_data, store_rx_packet_data;
  logic [7:0] tx_data, rx_packet_data;
  logic       get_rx_data, get_tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic [7:0] rx_data, tx_packet_data;

  int n_checks = 0;
  int n_fail   = 0;

  data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .flush                (flush),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_rx_data          (get_rx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .rx_data              (rx_data),
    .tx_packet_data       (tx_packet_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl, cl, stx;
    logic [7:0] txd;
    logic       srx;
    logic [7:0] rxd;
    logic       grx, gtx;
    logic [6:0] occ;
    logic [7:0] head;
  } vec_t;

  vec_t vecs[13];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input logic [6:0] occ, input logic [7:0] head);
    check8({name, ".occ"}, {1'b0, buffer_occupancy}, {1'b0, occ});
    check8({name, ".rx_data"}, rx_data, head);
    check8({name, ".tx_packet_data"}, tx_packet_data, head);
  endtask

  task automatic idle_inputs();
    flush = 0; clear = 0;
    store_tx_data = 0; tx_data = 8'h00;
    store_rx_packet_data = 0; rx_packet_data = 8'h00;
    get_rx_data = 0; get_tx_packet_data = 0;
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic cycle(input logic fl, input logic cl, input logic stx, input logic [7:0] txd,
                       input logic srx, input logic [7:0] rxd, input logic grx, input logic gtx);
    flush = fl; clear = cl;
    store_tx_data = stx; tx_data = txd;
    store_rx_packet_data = srx; rx_packet_data = rxd;
    get_rx_data = grx; get_tx_packet_data = gtx;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    //                fl cl stx txd    srx rxd    grx gtx occ    head
    vecs[0]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,8'h7C,1'b0,1'b0,7'd1,8'h7C};
    vecs[1]  = '{1'b1,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,7'd0,8'h00};
    vecs[2]  = '{1'b0,1'b0,1'b1,8'h22,1'b1,8'h11,1'b0,1'b0,7'd1,8'h11};
    vecs[3]  = '{1'b0,1'b0,1'b1,8'h33,1'b0,8'h00,1'b0,1'b0,7'd2,8'h11};
    vecs[4]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,7'd1,8'h33};
    vecs[5]  = '{1'b0,1'b0,1'b1,8'h44,1'b0,8'h00,1'b0,1'b1,7'd1,8'h44};
    vecs[6]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,7'd0,8'h00};
    vecs[7]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,8'h55,1'b0,1'b1,7'd1,8'h55};
    vecs[8]  = '{1'b1,1'b0,1'b0,8'h00,1'b1,8'h66,1'b1,1'b0,7'd0,8'h00};
    vecs[9]  = '{1'b0,1'b1,1'b1,8'h77,1'b0,8'h00,1'b0,1'b0,7'd0,8'h00};
    vecs[10] = '{1'b0,1'b0,1'b1,8'h88,1'b0,8'h00,1'b0,1'b0,7'd1,8'h88};
    vecs[11] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b0,7'd0,8'h00};
    vecs[12] = '{1'b0,1'b0,1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,7'd0,8'h00};

    idle_inputs();
    n_rst = 1'b0;
    #2;
    check_state("reset", 7'd0, 8'h00);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 13; v++) begin
      cycle(vecs[v].fl, vecs[v].cl, vecs[v].stx, vecs[v].txd,
            vecs[v].srx, vecs[v].rxd, vecs[v].grx, vecs[v].gtx);
      check_state($sformatf("vec%0d", v), vecs[v].occ, vecs[v].head);
    end

    // 20 bytes, flush, then fill to 64 and overflow attempt
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) cycle(0, 0, 0, 0, 1, 8'(i), 0, 0);
    check_state("fill20", 7'd20, 8'd1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    check_state("flush20", 7'd0, 8'h00);
    for (int i = 50; i <= 113; i++) cycle(0, 0, 0, 0, 1, 8'(i), 0, 0);
    check_state("full64", 7'd64, 8'd50);
    cycle(0, 0, 0, 0, 1, 8'd200, 0, 0);
    check_state("store_at_full", 7'd64, 8'd50);
    // store with concurrent get at full: get only
    cycle(0, 0, 0, 0, 1, 8'd201, 0, 1);
    check_state("full_store_get", 7'd63, 8'd51);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check_state("pop20", 7'd43, 8'd71);

    // TX-side fill and drain, checking every head byte
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 100; i <= 163; i++) cycle(0, 0, 1, 8'(i), 0, 0, 0, 0);
    check_state("tx_full", 7'd64, 8'd100);
    for (int i = 100; i <= 163; i++) begin
      check8($sformatf("tx_head%0d", i), tx_packet_data, 8'(i));
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
    end
    check_state("tx_drained", 7'd0, 8'h00);
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    check_state("get_at_empty", 7'd0, 8'h00);

    // Pointers now at 64; RX-side traffic continues without flush
    for (int i = 200; i <= 219; i++) cycle(0, 0, 0, 0, 1, 8'(i), 0, 0);
    check_state("rx20", 7'd20, 8'd200);
    for (int i = 200; i <= 219; i++) begin
      check8($sformatf("rx_head%0d", i), rx_data, 8'(i));
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
    end
    check_state("rx_drained", 7'd0, 8'h00);
    for (int i = 1; i <= 10; i++) cycle(0, 0, 0, 0, 1, 8'(i), 0, 0);
    check_state("occ10", 7'd10, 8'd1);
    // 51 store+get cycles push wptr past 128 to exercise wrap
    for (int j = 0; j < 51; j++) cycle(0, 0, 0, 0, 1, 8'(11 + j), 1, 0);
    check_state("concurrent_wrap", 7'd10, 8'd52);

    cycle(0, 0, 0, 0, 1, 8'hAA, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    check_state("clear", 7'd0, 8'h00);

    // Asynchronous reset in the middle of a 30-byte write burst
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 0, 1, 8'(i + 1), 0, 0);
    check_state("pre_reset", 7'd15, 8'd1);
    store_rx_packet_data = 1; rx_packet_data = 8'd16;
    #2;
    n_rst = 1'b0;
    #1;
    check_state("mid_reset", 7'd0, 8'h00);
    idle_inputs();
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_reset_idle", 7'd0, 8'h00);
    cycle(0, 0, 1, 8'h5A, 0, 0, 0, 0);
    check_state("post_reset_store", 7'd1, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
